// File: rtl/nf_bus_arbiter.sv
// nf_bus_arbiter
// Round-robin arbiter that shares the single data-memory master port of the
// load/store router between Master_n single-beat requesters.
// Optional feature: define NF_ARB_LOCK_EN to add the lock_m input. A locked
// owner keeps the bus for back-to-back transfers while it keeps requesting.
// Without the macro the arbiter is pure round-robin.
module nf_bus_arbiter #(
    parameter int Master_n = 2,
    parameter int RD_LAT   = 1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [Master_n-1:0]       req_m,
    input  logic [Master_n-1:0]       we_m,
    input  logic [Master_n-1:0][31:0] addr_m,
    input  logic [Master_n-1:0][31:0] wd_m,
`ifdef NF_ARB_LOCK_EN
    input  logic [Master_n-1:0]       lock_m,
`endif
    output logic [Master_n-1:0]       ack_m,
    output logic [31:0]               rd_m,
    output logic [31:0]               addr_dm_m,
    output logic                      we_dm_m,
    output logic [31:0]               wd_dm_m,
    input  logic [31:0]               rd_dm_m,
    output logic                      busy
);

    localparam int IDX_W = (Master_n > 1) ? $clog2(Master_n) : 1;
    localparam int CNT_W = 3;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(Master_n - 1);
    localparam logic [CNT_W-1:0] WAIT_INIT = (RD_LAT > 0) ? CNT_W'(RD_LAT - 1) : CNT_W'(0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [IDX_W-1:0]    r_owner;
    logic [IDX_W-1:0]    r_last_gnt;
    logic                r_we;
    logic [CNT_W-1:0]    r_cnt;

    logic [IDX_W-1:0]    w_rr_sel;
    logic [IDX_W-1:0]    w_idx;
    logic                w_found;
    logic [IDX_W-1:0]    w_grant;
    logic [Master_n-1:0] w_owner_hot;

`ifdef NF_ARB_LOCK_EN
    logic                r_lock;
`endif

    // Round-robin pick: first requester strictly after the last grant, wrapping.
    always_comb begin
        w_rr_sel = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int off = 1; off <= Master_n; off++) begin
            w_idx = IDX_W'((int'(r_last_gnt) + off) % Master_n);
            if (!w_found && req_m[w_idx]) begin
                w_found  = 1'b1;
                w_rr_sel = w_idx;
            end
        end
    end

`ifdef NF_ARB_LOCK_EN
    assign w_grant = (r_lock && req_m[r_owner]) ? r_owner : w_rr_sel;
`else
    assign w_grant = w_rr_sel;
`endif

    assign w_owner_hot = Master_n'(1) << r_owner;

    // Transfer sequencer: grant in IDLE, drive the router, collect read data, ack the owner.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_state    <= S_IDLE;
            r_owner    <= '0;
            r_last_gnt <= LAST_IDX;
            r_we       <= 1'b0;
            r_cnt      <= '0;
            ack_m      <= '0;
            rd_m       <= '0;
            addr_dm_m  <= '0;
            wd_dm_m    <= '0;
            we_dm_m    <= 1'b0;
            busy       <= 1'b0;
`ifdef NF_ARB_LOCK_EN
            r_lock     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    ack_m <= '0;
`ifdef NF_ARB_LOCK_EN
                    r_lock <= 1'b0;
`endif
                    if (|req_m) begin
                        r_owner    <= w_grant;
                        r_last_gnt <= w_grant;
                        r_we       <= we_m[w_grant];
                        addr_dm_m  <= addr_m[w_grant];
                        wd_dm_m    <= wd_m[w_grant];
                        we_dm_m    <= we_m[w_grant];
                        busy       <= 1'b1;
                        r_state    <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    we_dm_m <= 1'b0;
                    if (r_we) begin
                        ack_m   <= w_owner_hot;
                        r_state <= S_DONE;
                    end else if (RD_LAT == 0) begin
                        rd_m    <= rd_dm_m;
                        ack_m   <= w_owner_hot;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt   <= WAIT_INIT;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        rd_m    <= rd_dm_m;
                        ack_m   <= w_owner_hot;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    ack_m   <= '0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
`ifdef NF_ARB_LOCK_EN
                    if (lock_m[r_owner]) begin
                        r_lock <= 1'b1;
                    end
`endif
                end
                default: begin
                    ack_m   <= '0;
                    we_dm_m <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nf_bus_arbiter.sv
// tb_nf_bus_arbiter
// Directed and randomized checks of nf_bus_arbiter against a transaction-level
// model. Lock scenarios are included when NF_ARB_LOCK_EN is defined.
module tb_nf_bus_arbiter;

    localparam int N   = 3;
    localparam int LAT = 1;
    localparam int IW  = $clog2(N);

    logic                clk = 1'b0;
    logic                resetn;
    logic [N-1:0]        req_m;
    logic [N-1:0]        we_m;
    logic [N-1:0][31:0]  addr_m;
    logic [N-1:0][31:0]  wd_m;
    logic [N-1:0]        lock_m;
    logic [N-1:0]        ack_m;
    logic [31:0]         rd_m;
    logic [31:0]         addr_dm_m;
    logic                we_dm_m;
    logic [31:0]         wd_dm_m;
    logic [31:0]         rd_dm_m;
    logic                busy;
    logic [31:0]         addrDly = 32'h0;

    int vectors     = 0;
    int miscompares = 0;

    // transaction-level model state
    bit          mActive;
    int          mPhase;
    int          mDur;
    int          mOwner;
    int          mLastGnt;
    bit          mWr;
    logic [31:0] mAddr;
    logic [31:0] mWd;
    logic [31:0] mRd;
    bit          mLock;
    logic [N-1:0] expAck;
    int          ackLog[$];
    bit          autoMasters;
    bit          pending[N];

    nf_bus_arbiter #(.Master_n(N), .RD_LAT(LAT)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_m     (req_m),
        .we_m      (we_m),
        .addr_m    (addr_m),
        .wd_m      (wd_m),
`ifdef NF_ARB_LOCK_EN
        .lock_m    (lock_m),
`endif
        .ack_m     (ack_m),
        .rd_m      (rd_m),
        .addr_dm_m (addr_dm_m),
        .we_dm_m   (we_dm_m),
        .wd_dm_m   (wd_dm_m),
        .rd_dm_m   (rd_dm_m),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // slave memory: fixed content, one cycle of read latency
    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'h20) return 32'h1234_5678;
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    always @(posedge clk) addrDly <= addr_dm_m;
    assign rd_dm_m = rom(addrDly);

    function automatic bit bitOf(input logic [N-1:0] v, input int i);
        return v[IW'(i)];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mActive  = 0;
        mPhase   = 0;
        mDur     = 0;
        mOwner   = 0;
        mLastGnt = N - 1;
        mWr      = 0;
        mAddr    = '0;
        mWd      = '0;
        mRd      = '0;
        mLock    = 0;
        expAck   = '0;
    endtask

    // advance the model by one clock using the inputs about to be sampled
    task automatic modelStep();
        int pick;
        int c;
        pick = -1;
        if (!mActive) begin
            if (mLock && bitOf(req_m, mOwner)) begin
                pick = mOwner;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    c = (mLastGnt + k) % N;
                    if (pick < 0 && bitOf(req_m, c)) pick = c;
                end
            end
            mLock = 0;
            if (pick >= 0) begin
                mActive  = 1;
                mPhase   = 1;
                mOwner   = pick;
                mLastGnt = pick;
                mWr      = bitOf(we_m, pick);
                mAddr    = addr_m[IW'(pick)];
                mWd      = wd_m[IW'(pick)];
                mDur     = mWr ? 2 : 2 + LAT;
            end
        end else if (mPhase == mDur) begin
`ifdef NF_ARB_LOCK_EN
            if (bitOf(lock_m, mOwner)) mLock = 1;
`endif
            mActive = 0;
            mPhase  = 0;
        end else begin
            mPhase++;
        end
        if (mActive && !mWr && mPhase == mDur) mRd = rom(mAddr);
        expAck = (mActive && mPhase == mDur) ? (N'(1) << mOwner) : '0;
    endtask

    task automatic compareAll(input string ph);
        checkOutput({ph, "_ack"},  32'(ack_m),   32'(expAck));
        checkOutput({ph, "_busy"}, 32'(busy),    32'(mActive));
        checkOutput({ph, "_we"},   32'(we_dm_m), 32'(mActive && mPhase == 1 && mWr));
        checkOutput({ph, "_addr"}, addr_dm_m,    mAddr);
        checkOutput({ph, "_wd"},   wd_dm_m,      mWd);
        checkOutput({ph, "_rd"},   rd_m,         mRd);
    endtask

    task automatic applyStimulus(input int i, input bit we, input logic [31:0] addr, input logic [31:0] wd);
        req_m[IW'(i)]  = 1'b1;
        we_m[IW'(i)]   = we;
        addr_m[IW'(i)] = addr;
        wd_m[IW'(i)]   = wd;
    endtask

    task automatic clearMasters();
        req_m  = '0;
        we_m   = '0;
        addr_m = '0;
        wd_m   = '0;
        lock_m = '0;
        for (int i = 0; i < N; i++) pending[i] = 0;
    endtask

    task automatic driveMasters();
        for (int i = 0; i < N; i++) begin
            if (bitOf(expAck, i)) begin
                pending[i] = 0;
                if ($urandom_range(1, 0) == 1) begin
                    pending[i] = 1;
                    applyStimulus(i, $urandom_range(1, 0) == 1, $urandom & 32'h0000_FFFC, $urandom);
                end else begin
                    req_m[IW'(i)] = 1'b0;
                end
            end else if (!pending[i]) begin
                if ($urandom_range(2, 0) == 0) begin
                    pending[i] = 1;
                    applyStimulus(i, $urandom_range(1, 0) == 1, $urandom & 32'h0000_FFFC, $urandom);
                end
            end else if (mActive && mOwner == i && mPhase < mDur && $urandom_range(7, 0) == 0) begin
                req_m[IW'(i)] = 1'b0;
            end
        end
        lock_m = N'($urandom);
    endtask

    task automatic tick(input string ph);
        modelStep();
        @(posedge clk);
        #1;
        compareAll(ph);
        for (int i = 0; i < N; i++) if (bitOf(ack_m, i)) ackLog.push_back(i);
        if (autoMasters) driveMasters();
    endtask

    task automatic applyReset();
        resetn = 1'b1;
        #1;
        modelReset();
        compareAll("rst_async");
        repeat (2) @(posedge clk);
        #1;
        compareAll("rst_hold");
        resetn = 1'b0;
    endtask

    initial begin
        int cnt0;
        int cnt1;
        resetn      = 1'b0;
        autoMasters = 0;
        clearMasters();
        modelReset();
        #2;

        // reset then idle bus
        applyReset();
        repeat (5) tick("idle");

        // single write from master 0
        applyStimulus(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        tick("wr");
        checkOutput("wr_we_pulse", 32'(we_dm_m), 32'd1);
        checkOutput("wr_addr", addr_dm_m, 32'h10);
        checkOutput("wr_data", wd_dm_m, 32'hDEAD_BEEF);
        tick("wr");
        checkOutput("wr_ack", 32'(ack_m), 32'b001);
        req_m = '0;
        tick("wr");

        // single read from master 1
        applyStimulus(1, 1'b0, 32'h20, 32'h0);
        tick("rd");
        checkOutput("rd_no_we", 32'(we_dm_m), 32'd0);
        tick("rd");
        checkOutput("rd_no_ack_wait", 32'(ack_m), 32'd0);
        tick("rd");
        checkOutput("rd_ack", 32'(ack_m), 32'b010);
        checkOutput("rd_data", rd_m, 32'h1234_5678);
        req_m = '0;
        tick("rd");

        // fairness with two continuous requesters
        applyStimulus(0, 1'b1, 32'h100, 32'hA0A0_0001);
        applyStimulus(1, 1'b0, 32'h204, 32'h0);
        ackLog.delete();
        for (int t = 0; t < 100 && ackLog.size() < 8; t++) tick("fair");
        checkOutput("fair_acks", 32'(ackLog.size()), 32'd8);
        cnt0 = 0;
        cnt1 = 0;
        foreach (ackLog[k]) begin
            if (ackLog[k] == 0) cnt0++;
            if (ackLog[k] == 1) cnt1++;
        end
        checkOutput("fair_m0_count", 32'(cnt0), 32'd4);
        checkOutput("fair_m1_count", 32'(cnt1), 32'd4);
        if (ackLog.size() >= 4) begin
            checkOutput("fair_order0", 32'(ackLog[0]), 32'd0);
            checkOutput("fair_order1", 32'(ackLog[1]), 32'd1);
            checkOutput("fair_order2", 32'(ackLog[2]), 32'd0);
            checkOutput("fair_order3", 32'(ackLog[3]), 32'd1);
        end
        req_m = '0;
        tick("fair");

        // reset in the middle of a read wait
        applyStimulus(1, 1'b0, 32'h40, 32'h0);
        tick("abort");
        tick("abort");
        req_m = '0;
        applyReset();
        checkOutput("abort_no_ack", 32'(ack_m), 32'd0);
        applyStimulus(0, 1'b0, 32'h44, 32'h0);
        applyStimulus(1, 1'b0, 32'h48, 32'h0);
        ackLog.delete();
        for (int t = 0; t < 20 && ackLog.size() < 1; t++) tick("abort");
        checkOutput("abort_first_ack", 32'(ackLog.size()), 32'd1);
        if (ackLog.size() >= 1) checkOutput("abort_next_m0", 32'(ackLog[0]), 32'd0);
        req_m = '0;
        tick("abort");

`ifdef NF_ARB_LOCK_EN
        // lock keeps master 0 on the bus until released
        applyReset();
        clearMasters();
        lock_m[0] = 1'b1;
        applyStimulus(0, 1'b1, 32'h300, 32'h1111_0000);
        applyStimulus(1, 1'b1, 32'h304, 32'h2222_0000);
        ackLog.delete();
        for (int t = 0; t < 60 && ackLog.size() < 4; t++) begin
            tick("lock");
            if (ackLog.size() == 3) lock_m[0] = 1'b0;
        end
        checkOutput("lock_acks", 32'(ackLog.size()), 32'd4);
        if (ackLog.size() >= 4) begin
            checkOutput("lock_g0", 32'(ackLog[0]), 32'd0);
            checkOutput("lock_g1", 32'(ackLog[1]), 32'd0);
            checkOutput("lock_g2", 32'(ackLog[2]), 32'd0);
            checkOutput("lock_g3", 32'(ackLog[3]), 32'd1);
        end
        clearMasters();
        tick("lock");
`endif

        // randomized traffic from all masters
        applyReset();
        clearMasters();
        autoMasters = 1;
        repeat (800) tick("rand");
        autoMasters = 0;
        clearMasters();
        repeat (8) tick("drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
